memory_controller: RTL

Sits directly downstream of the multicycle core's memory bus (memory_read, memory_write, address, write_data, read_data). It decodes each core request to on-chip synchronous block RAM or to a memory-mapped peripheral port. It sequences the access with a small FSM and returns read data plus a one-cycle ready pulse. The core holds its request until that pulse.

---
 rtl/memory_controller_pkg.sv | 21 ++
 rtl/memory_controller_address_decoder.sv | 29 ++
 rtl/memory_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_pkg.sv
// Shared types for the memory controller: FSM states, address regions and the
// read data returned for unmapped or timed-out accesses.
package memory_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAM_ACCESS,
    RAM_WAIT,
    PERIPH_WAIT,
    RESPOND
  } state_e;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_PERIPH,
    REGION_UNMAPPED
  } region_e;

  localparam logic [31:0] ERROR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/memory_controller_address_decoder.sv
// Combinational address decode: region of a byte address and its RAM word index.
// Zero latency; no flow control.
module address_decoder
  import memory_controller_pkg::*;
#(
  parameter int          RAM_WORDS   = 4096,
  parameter logic [31:0] PERIPH_BASE = 32'h8000_0000,
  localparam int         AW          = $clog2(RAM_WORDS)
) (
  input  logic [31:0]   addr_i,
  output logic [1:0]    region_o,
  output logic [AW-1:0] word_addr_o
);

  // One extra bit so a RAM that fills the whole 32-bit space still compares correctly.
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  always_comb begin
    region_o = REGION_UNMAPPED;
    if ({1'b0, addr_i} < RAM_BYTES) begin
      region_o = REGION_RAM;
    end else if (addr_i >= PERIPH_BASE) begin
      region_o = REGION_PERIPH;
    end
  end

  assign word_addr_o = addr_i[AW+1:2];

endmodule

// File: rtl/memory_controller.sv
// Routes held core requests to block RAM or a peripheral port and returns a one-cycle
// ready pulse (RAM write 2, RAM read 3, unmapped 1, peripheral ack+1 cycles).
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int          RAM_WORDS      = 4096,
  parameter logic [31:0] PERIPH_BASE    = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 16,
  localparam int         AW             = $clog2(RAM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_read,
  input  logic          core_write,
  input  logic [31:0]   core_address,
  input  logic [31:0]   core_write_data,
  output logic [31:0]   core_read_data,
  output logic          core_ready,
  output logic          bus_error,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          periph_req,
  output logic          periph_we,
  output logic [31:0]   periph_addr,
  output logic [31:0]   periph_wdata,
  input  logic [31:0]   periph_rdata,
  input  logic          periph_ack
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  logic [1:0]    region_raw;
  region_e       region;
  logic [AW-1:0] word_addr;

  address_decoder #(
    .RAM_WORDS   (RAM_WORDS),
    .PERIPH_BASE (PERIPH_BASE)
  ) u_decoder (
    .addr_i      (core_address),
    .region_o    (region_raw),
    .word_addr_o (word_addr)
  );

  assign region = region_e'(region_raw);

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic          preq_q, preq_d;
  logic          pwe_q, pwe_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic          ready_q, ready_d;
  logic          berr_q, berr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    preq_d      = preq_q;
    pwe_d       = pwe_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    ready_d     = 1'b0;
    berr_d      = 1'b0;
    rdata_d     = rdata_q;

    unique case (state_q)
      IDLE: begin
        cnt_d   = 8'd0;
        rdata_d = 32'h0;
        if (core_read || core_write) begin
          // A simultaneous read and write is serviced as a read.
          we_d = core_write && !core_read;
          unique case (region)
            REGION_RAM: begin
              state_d     = RAM_ACCESS;
              ram_en_d    = 1'b1;
              ram_we_d    = we_d;
              ram_addr_d  = word_addr;
              ram_wdata_d = core_write_data;
            end
            REGION_PERIPH: begin
              state_d  = PERIPH_WAIT;
              preq_d   = 1'b1;
              pwe_d    = we_d;
              paddr_d  = core_address;
              pwdata_d = core_write_data;
            end
            default: begin
              state_d = RESPOND;
              ready_d = 1'b1;
              berr_d  = 1'b1;
              rdata_d = we_d ? 32'h0 : ERROR_DATA;
            end
          endcase
        end
      end
      RAM_ACCESS: begin
        if (we_q) begin
          state_d = RESPOND;
          ready_d = 1'b1;
        end else begin
          state_d = RAM_WAIT;
        end
      end
      RAM_WAIT: begin
        state_d = RESPOND;
        ready_d = 1'b1;
        rdata_d = ram_rdata;
      end
      PERIPH_WAIT: begin
        cnt_d = cnt_inc;
        // Ack is checked first so it wins in the cycle the limit is reached.
        if (periph_ack) begin
          state_d = RESPOND;
          preq_d  = 1'b0;
          ready_d = 1'b1;
          rdata_d = we_q ? 32'h0 : periph_rdata;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_d = RESPOND;
          preq_d  = 1'b0;
          ready_d = 1'b1;
          berr_d  = 1'b1;
          rdata_d = we_q ? 32'h0 : ERROR_DATA;
        end
      end
      RESPOND: begin
        state_d = IDLE;
        rdata_d = 32'h0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= 8'd0;
      we_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
      preq_q      <= 1'b0;
      pwe_q       <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      ready_q     <= 1'b0;
      berr_q      <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      preq_q      <= preq_d;
      pwe_q       <= pwe_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      ready_q     <= ready_d;
      berr_q      <= berr_d;
      rdata_q     <= rdata_d;
    end
  end

  assign core_read_data = rdata_q;
  assign core_ready     = ready_q;
  assign bus_error      = berr_q;
  assign ram_en         = ram_en_q;
  assign ram_we         = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wdata      = ram_wdata_q;
  assign periph_req     = preq_q;
  assign periph_we      = pwe_q;
  assign periph_addr    = paddr_q;
  assign periph_wdata   = pwdata_q;

endmodule
